// File: rtl/icache_2way.sv
// icache_2way: two-way set-associative instruction cache with one outstanding
// miss, same-cycle bypass of the returning word, per-set LRU replacement,
// single-cycle flush and hit/miss performance counters.
//
// Ports:
//   clk_in, rst_n_in       clock, asynchronous active-low reset
//   rdy_in                 global enable; all state holds when low
//   flush_in               invalidate every entry (fence.i)
//   is_fetch, pc           fetch request and address
//   is_ret, ret            combinational fetch response
//   is_send_mem, send_addr memory read request (level-held) and address
//   is_mem_back, back_ins  memory response pulse and data
//   hit_cnt, miss_cnt      performance counters (wrap around)
module icache_2way #(
    parameter int ADDR_W = 17,
    parameter int IDX_W  = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              is_fetch,
    input  logic [31:0]       pc,
    output logic              is_ret,
    output logic [31:0]       ret,
    output logic              is_send_mem,
    output logic [31:0]       send_addr,
    input  logic              is_mem_back,
    input  logic [31:0]       back_ins,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int TAG_W = ADDR_W - 1 - IDX_W;
    localparam int SETS  = 1 << IDX_W;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REFILL = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    logic [1:0]       state;
    logic [31:0]      data0 [SETS];
    logic [31:0]      data1 [SETS];
    logic [TAG_W-1:0] tag0  [SETS];
    logic [TAG_W-1:0] tag1  [SETS];
    logic [SETS-1:0]  valid0;
    logic [SETS-1:0]  valid1;
    logic [SETS-1:0]  lru;      // way to evict next

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] fill_tag;
    logic             hit0;
    logic             hit1;
    logic             bypass;
    logic             array_hit;
    logic             do_fill;
    logic             victim;

    assign idx      = pc[IDX_W:1];
    assign tag      = pc[ADDR_W-1:IDX_W+1];
    assign fill_idx = send_addr[IDX_W:1];
    assign fill_tag = send_addr[ADDR_W-1:IDX_W+1];

    assign hit0   = valid0[idx] && (tag0[idx] == tag);
    assign hit1   = valid1[idx] && (tag1[idx] == tag);
    assign bypass = (state == REFILL) && is_mem_back && (send_addr == pc);
    assign is_ret = is_fetch && !flush_in && (hit0 || hit1 || bypass);

    // A bypassed word is never also resident, but excluding it keeps the
    // hit counter strictly about array hits.
    assign array_hit = is_fetch && !flush_in && (hit0 || hit1) && !bypass;
    assign do_fill   = rdy_in && !flush_in && (state == REFILL) && is_mem_back;

    // First invalid way (way 0 preferred), else the LRU way. Uses the LRU
    // value from before this cycle's hit update.
    assign victim = !valid0[fill_idx] ? 1'b0 :
                    !valid1[fill_idx] ? 1'b1 : lru[fill_idx];

    always_comb begin
        ret = data1[idx];
        if (bypass)
            ret = back_ins;
        else if (hit0)
            ret = data0[idx];
    end

    // ---- control state: FSM, request, counters, valid/LRU ----
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            is_send_mem <= 1'b0;
            send_addr   <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            valid0      <= '0;
            valid1      <= '0;
            lru         <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                valid0 <= '0;
                valid1 <= '0;
                lru    <= '0;
                // An outstanding request must still be consumed; a response
                // arriving right now retires it without filling.
                if (state != IDLE) begin
                    if (is_mem_back) begin
                        state       <= IDLE;
                        is_send_mem <= 1'b0;
                    end else begin
                        state <= DRAIN;
                    end
                end
            end else begin
                if (array_hit) begin
                    hit_cnt  <= hit_cnt + CNT_W'(1);
                    lru[idx] <= hit0;
                end
                case (state)
                    IDLE: begin
                        if (is_fetch && !hit0 && !hit1) begin
                            is_send_mem <= 1'b1;
                            send_addr   <= pc;
                            miss_cnt    <= miss_cnt + CNT_W'(1);
                            state       <= REFILL;
                        end
                    end
                    REFILL: begin
                        if (is_mem_back) begin
                            if (victim)
                                valid1[fill_idx] <= 1'b1;
                            else
                                valid0[fill_idx] <= 1'b1;
                            // Written after the hit update so the fresh line
                            // is most recent even if the same set was hit.
                            lru[fill_idx] <= ~victim;
                            is_send_mem   <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                    DRAIN: begin
                        if (is_mem_back) begin
                            is_send_mem <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // ---- data/tag arrays: written on fill only ----
    always_ff @(posedge clk_in) begin
        if (do_fill) begin
            if (victim) begin
                data1[fill_idx] <= back_ins;
                tag1[fill_idx]  <= fill_tag;
            end else begin
                data0[fill_idx] <= back_ins;
                tag0[fill_idx]  <= fill_tag;
            end
        end
    end
endmodule

// File: tb/tb_icache_2way.sv
module tb_icache_2way;
    localparam int ADDR_W = 17;
    localparam int IDX_W  = 8;
    localparam int CNT_W  = 32;
    localparam int SETS   = 1 << IDX_W;

    logic             clk_in = 1'b0;
    logic             rst_n_in = 1'b1;
    logic             rdy_in = 1'b0;
    logic             flush_in = 1'b0;
    logic             is_fetch = 1'b0;
    logic [31:0]      pc = '0;
    logic             is_mem_back = 1'b0;
    logic [31:0]      back_ins = '0;
    logic             is_ret;
    logic [31:0]      ret;
    logic             is_send_mem;
    logic [31:0]      send_addr;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    icache_2way #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .is_fetch(is_fetch), .pc(pc), .is_ret(is_ret), .ret(ret),
        .is_send_mem(is_send_mem), .send_addr(send_addr),
        .is_mem_back(is_mem_back), .back_ins(back_ins),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: each set is a recency list of resident addresses,
    // slot 0 least recently used, slot 1 most recently used.
    int          m_cnt  [SETS];
    logic [31:0] m_line [SETS][2];
    logic [31:0] m_word [SETS][2];
    bit          m_pend;
    bit          m_drain;
    logic [31:0] m_addr;
    logic [31:0] m_hit;
    logic [31:0] m_miss;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h01234567;
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'(a[IDX_W:1]);
    endfunction

    function automatic int m_slot(input logic [31:0] a);
        int s = set_of(a);
        for (int i = 0; i < m_cnt[s]; i++)
            if (m_line[s][i] == a) return i;
        return -1;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < SETS; i++) m_cnt[i] = 0;
    endtask

    task automatic m_reset();
        m_clear();
        m_pend = 0; m_drain = 0; m_addr = '0; m_hit = '0; m_miss = '0;
    endtask

    task automatic m_touch(input int s, input int slot);
        logic [31:0] ta, td;
        if (slot == 0 && m_cnt[s] == 2) begin
            ta = m_line[s][0]; td = m_word[s][0];
            m_line[s][0] = m_line[s][1]; m_word[s][0] = m_word[s][1];
            m_line[s][1] = ta; m_word[s][1] = td;
        end
    endtask

    // Evicts the given address (chosen before this cycle's hit) and makes the
    // new line most recent.
    task automatic m_fill(input logic [31:0] a, input logic [31:0] d, input logic [31:0] evict);
        int s = set_of(a);
        if (m_cnt[s] < 2) begin
            m_line[s][m_cnt[s]] = a; m_word[s][m_cnt[s]] = d;
            m_cnt[s]++;
        end else begin
            if (m_line[s][0] == evict) begin
                m_line[s][0] = m_line[s][1]; m_word[s][0] = m_word[s][1];
            end
            m_line[s][1] = a; m_word[s][1] = d;
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check the
    // combinational response, update the model at the rising edge, then
    // check registered outputs at the next falling edge.
    task automatic cycle(input bit r, input bit f, input bit fe, input logic [31:0] p,
                         input bit mb, input logic [31:0] bd, output bit got_ret);
        int slot, fs;
        bit hit, byp, exp_ret;
        logic [31:0] exp_word, evict;
        rdy_in = r; flush_in = f; is_fetch = fe; pc = p; is_mem_back = mb; back_ins = bd;
        #1;
        slot = m_slot(p);
        hit = (slot >= 0);
        byp = m_pend && !m_drain && mb && (m_addr == p);
        exp_ret = fe && !f && (hit || byp);
        exp_word = bd;
        if (!byp && hit) exp_word = m_word[set_of(p)][slot];
        check("is_ret", is_ret, exp_ret);
        if (exp_ret) check("ret", ret, exp_word);
        got_ret = is_ret;
        @(posedge clk_in);
        if (r) begin
            if (f) begin
                m_clear();
                if (m_pend) begin
                    if (mb) begin m_pend = 0; m_drain = 0; end
                    else m_drain = 1;
                end
            end else begin
                fs = set_of(m_addr);
                evict = m_line[fs][0];
                if (fe && hit && !byp) begin
                    m_hit++;
                    m_touch(set_of(p), slot);
                end
                if (!m_pend) begin
                    if (fe && !hit) begin m_pend = 1; m_addr = p; m_miss++; end
                end else if (mb) begin
                    if (!m_drain) m_fill(m_addr, bd, evict);
                    m_pend = 0; m_drain = 0;
                end
            end
        end
        @(negedge clk_in);
        check("is_send_mem", is_send_mem, m_pend);
        if (m_pend) check("send_addr", send_addr, m_addr);
        check("hit_cnt", hit_cnt, m_hit);
        check("miss_cnt", miss_cnt, m_miss);
    endtask

    task automatic apply_reset();
        rst_n_in = 1'b0;
        #1;
        check("rst_send_mem", is_send_mem, 1'b0);
        check("rst_send_addr", send_addr, 32'h0);
        check("rst_hit_cnt", hit_cnt, 32'h0);
        check("rst_miss_cnt", miss_cnt, 32'h0);
        m_reset();
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    task automatic fill_line(input logic [31:0] a);
        bit g;
        cycle(1, 0, 1, a, 0, '0, g);
        cycle(1, 0, 1, a, 1, memw(a), g);
    endtask

    initial begin
        bit g;
        bit r, f, fe, mb;
        logic [31:0] p, bd;
        logic [31:0] saved;
        int lat;

        #2;
        apply_reset();

        // Cold miss, bypass, then hit
        cycle(1, 0, 1, 32'h100, 0, '0, g);
        check("cold_miss_ret", g, 1'b0);
        check("cold_req", is_send_mem, 1'b1);
        check("cold_addr", send_addr, 32'h100);
        cycle(1, 0, 1, 32'h100, 1, 32'hDEADBEEF, g);
        check("cold_bypass", g, 1'b1);
        cycle(1, 0, 1, 32'h100, 0, '0, g);
        check("cold_hit", g, 1'b1);
        check("cold_ret", ret, 32'hDEADBEEF);
        check("cold_hit_cnt", hit_cnt, 32'd1);
        check("cold_miss_cnt", miss_cnt, 32'd1);

        // LRU replacement within set 0
        apply_reset();
        fill_line(32'h0000);
        fill_line(32'h0200);
        cycle(1, 0, 1, 32'h0000, 0, '0, g);
        check("lru_hit0", g, 1'b1);
        fill_line(32'h0400);
        cycle(1, 0, 1, 32'h0000, 0, '0, g);
        check("lru_keep", g, 1'b1);
        cycle(1, 0, 1, 32'h0200, 0, '0, g);
        check("lru_evicted", g, 1'b0);
        cycle(1, 0, 0, 32'h0, 1, memw(32'h0200), g);

        // Flush during refill
        cycle(1, 0, 1, 32'h40, 0, '0, g);
        cycle(1, 1, 0, 32'h40, 0, '0, g);
        check("flush_pending", is_send_mem, 1'b1);
        cycle(1, 0, 1, 32'h40, 1, memw(32'h40), g);
        check("flush_no_bypass", g, 1'b0);
        check("flush_idle", is_send_mem, 1'b0);
        cycle(1, 0, 1, 32'h40, 0, '0, g);
        check("flush_remiss", g, 1'b0);
        check("flush_reissue", is_send_mem, 1'b1);
        cycle(1, 0, 0, 32'h0, 1, memw(32'h40), g);

        // Hit under miss with pc change
        fill_line(32'h10);
        cycle(1, 0, 1, 32'h20, 0, '0, g);
        cycle(1, 0, 1, 32'h10, 0, '0, g);
        check("hum_hit", g, 1'b1);
        cycle(1, 0, 1, 32'h10, 1, memw(32'h20), g);
        check("hum_hit_resp", g, 1'b1);
        check("hum_ret", ret, memw(32'h10));
        cycle(1, 0, 1, 32'h20, 0, '0, g);
        check("hum_filled", g, 1'b1);

        // rdy_in low holds everything
        saved = miss_cnt;
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'h300, 0, '0, g);
        check("rdy_no_req", is_send_mem, 1'b0);
        check("rdy_miss_hold", miss_cnt, saved);
        cycle(1, 0, 1, 32'h300, 0, '0, g);
        check("rdy_resume", is_send_mem, 1'b1);
        cycle(1, 0, 1, 32'h300, 1, memw(32'h300), g);
        check("rdy_bypass", g, 1'b1);

        // Reset during refill
        cycle(1, 0, 1, 32'h500, 0, '0, g);
        apply_reset();
        cycle(1, 0, 0, 32'h0, 1, memw(32'h500), g);
        check("rst_late_resp", is_send_mem, 1'b0);
        cycle(1, 0, 1, 32'h10, 0, '0, g);
        check("rst_all_miss", g, 1'b0);
        cycle(1, 0, 0, 32'h0, 1, memw(32'h10), g);
        cycle(1, 0, 1, 32'h500, 0, '0, g);
        check("rst_no_fill", g, 1'b0);
        cycle(1, 0, 0, 32'h0, 1, memw(32'h500), g);

        // Randomized traffic on a small address pool that forces set conflicts
        lat = 0;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 9) != 0);
            f  = ($urandom_range(0, 49) == 0);
            fe = ($urandom_range(0, 4) != 0);
            p  = (32'($urandom_range(0, 3)) << (IDX_W + 1)) | (32'($urandom_range(0, 3)) << 1);
            if (m_pend && $urandom_range(0, 2) == 0) p = m_addr;
            mb = 0;
            bd = $urandom;
            if (m_pend) begin
                if (lat == 0) begin
                    if (r) begin
                        mb = 1;
                        bd = memw(m_addr);
                        lat = $urandom_range(0, 3);
                    end
                end else begin
                    lat--;
                end
            end
            cycle(r, f, fe, p, mb, bd, g);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/icache_2way.md
# icache_2way

Parametrised two-way set-associative instruction cache between the instruction fetch unit and the memory controller. It returns hits combinationally in the same cycle as the fetch and handles one outstanding miss at a time with same-cycle bypass of the returning word. Compared with the direct-mapped cache it adds configurable depth, per-set LRU replacement, a single-cycle flush (fence.i) and hit/miss performance counters.

## Interface
- ADDR_W, 17, number of cached address bits; pc[0] is always 0.
- IDX_W, 8, set-index width; the cache has 2^IDX_W sets × 2 ways, one 32-bit word per entry.
- CNT_W, 32, width of the performance counters.
- Derived, not a parameter: TAG_W = ADDR_W-1-IDX_W; index = pc[IDX_W:1]; tag = pc[ADDR_W-1:IDX_W+1].

Ports:
- clk_in  in  1  clock; all state changes on rising edge.
- rst_n_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global enable; when 0, all state holds.
- flush_in  in  1  invalidate the whole cache (fence.i).
- is_fetch  in  1  fetch request valid.
- pc  in  32  fetch address.
- is_ret  out  1  fetch data valid this cycle (combinational).
- ret  out  32  fetched instruction (combinational).
- is_send_mem  out  1  memory read request, level-held until response.
- send_addr  out  32  memory read address.
- is_mem_back  in  1  memory response valid, one-cycle pulse.
- back_ins  in  32  memory response data.
- hit_cnt  out  CNT_W  array hits counted.
- miss_cnt  out  CNT_W  misses issued.

## Operation
- Storage per set: data[2], tag[2] (TAG_W bits), valid[2], and one lru bit (the way to evict next).
- Hit condition: hit_w = valid[w] && tag[w] == pc tag, for each way w.
- Bypass condition: bypass = state==REFILL && is_mem_back && send_addr==pc, comparing all 32 bits.
- is_ret = is_fetch && !flush_in && (hit_0 || hit_1 || bypass).
- ret priority: back_ins if bypass, else data of way 0 if hit_0, else data of way 1. Value is don't-care when is_ret=0.
- FSM states: IDLE, REFILL, DRAIN.
  - IDLE: on is_fetch && !hit && !flush_in, set is_send_mem<=1, send_addr<=pc, increment miss_cnt, and go to REFILL.
  - REFILL: on is_mem_back, write the victim way of set send_addr[IDX_W:1] (data, tag, valid=1), set lru to the other way, set is_send_mem<=0, and go to IDLE.
  - Victim selection: first invalid way, preferring way 0; otherwise the way given by lru.
  - DRAIN (entered from REFILL on flush_in): waits for is_mem_back, performs no fill and no bypass, then clears is_send_mem and goes to IDLE.
- Array hits are served in every state (hit-under-miss). Each array hit with rdy_in increments hit_cnt and sets that set's lru to the non-hit way. A bypass return is not counted as a hit.
- flush_in (with rdy_in) clears every valid bit and every lru bit in one cycle. It has priority over a miss issue and over a fill in the same cycle; a simultaneous is_mem_back in REFILL goes straight to IDLE without a fill.
- Counters wrap modulo 2^CNT_W.
- The pc may change during REFILL; the fill always targets send_addr.
- A response arriving in IDLE is ignored.

## Timing
- Reset (asynchronous, rst_n_in=0): state=IDLE, is_send_mem=0, send_addr=0, hit_cnt=0, miss_cnt=0, all valid=0, all lru=0. is_ret follows combinationally: 0 after reset.
- Reset mid-refill abandons the request; the late response is ignored.
- Hit latency is 0 cycles, combinational from pc.
- Miss latency: is_send_mem rises the edge after the miss cycle. Data is returned by bypass in the cycle is_mem_back is high, if pc is unchanged, and is in the array from the next cycle.
- rdy_in=0: no FSM transition, no array or counter update, no flush. A response arriving in that cycle is lost; memory must not pulse is_mem_back while rdy_in=0. is_ret/ret stay combinational.
- Only one request is ever outstanding; send_addr is stable while is_send_mem=1.

## Test plan
- Cold miss: reset, fetch pc=0x100 → is_send_mem=1 and send_addr=0x100 next cycle; response 0xDEADBEEF → is_ret=1 and ret=0xDEADBEEF that cycle; refetch → hit, hit_cnt=1, miss_cnt=1.
- LRU with IDX_W=8: fill 0x0000 and 0x0200 (same set 0), hit 0x0000, then miss 0x0400 → 0x0200 is evicted; 0x0000 still hits, 0x0200 misses.
- Flush mid-refill: miss 0x40, assert flush_in, then respond → no fill, is_ret=0, state IDLE; 0x40 misses again.
- Hit under miss with pc change: 0x10 is cached, miss 0x20, switch pc to 0x10 → is_ret=1 from the array; response for 0x20 produces no bypass and fills the entry.
- rdy_in=0 for 3 cycles during a miss → no request issued and counters unchanged; resumes correctly once rdy_in=1.
- Reset asserted mid-REFILL → is_send_mem=0 immediately; a later is_mem_back is ignored and all entries miss.
